// File: rtl/key_chain_detector_if.sv
// Key-chain detector bus: raw active-low push-buttons in, debounced levels,
// sequence progress and result pulses out.
//   key1..key4 : raw buttons, 0 = pressed, asynchronous to clk
//   key_state  : debounced key levels, 1 = pressed (bit0 = key1)
//   step       : keys correctly pressed so far in the current sequence
//   fwd_ok     : one-cycle pulse, order key1..key4 completed
//   rev_ok     : one-cycle pulse, order key4..key1 completed
//   seq_err    : one-cycle pulse, sequence aborted
interface key_chain_detector_if;
  logic       key1;
  logic       key2;
  logic       key3;
  logic       key4;
  logic [3:0] key_state;
  logic [2:0] step;
  logic       fwd_ok;
  logic       rev_ok;
  logic       seq_err;

  // Button side / environment
  modport master (
    output key1, key2, key3, key4,
    input  key_state, step, fwd_ok, rev_ok, seq_err
  );

  // Detector side
  modport slave (
    input  key1, key2, key3, key4,
    output key_state, step, fwd_ok, rev_ok, seq_err
  );
endinterface

// File: rtl/key_chain_detector.sv
// Key-chain detector: synchronizes and debounces four push-buttons, then
// recognises the press order key1->key4 (fwd_ok) or key4->key1 (rev_ok).
// Wrong keys, simultaneous presses or too long a pause abort the sequence
// with seq_err.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   kc    : key_chain_detector_if.slave (keys in, state/step/pulses out)
module key_chain_detector #(
  parameter int unsigned CPU_CLK         = 25_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = CPU_CLK / 100,
  parameter int unsigned STEP_TIMEOUT    = CPU_CLK
) (
  input  logic                  clk,
  input  logic                  rst_n,
  key_chain_detector_if.slave   kc
);

  localparam int unsigned NKEYS  = 4;
  localparam int unsigned DB_MAX = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;
  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TO_MAX = (STEP_TIMEOUT > 0) ? STEP_TIMEOUT - 1 : 0;
  localparam int unsigned TO_W   = (STEP_TIMEOUT > 1) ? $clog2(STEP_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2
  } state_e;

  logic [NKEYS-1:0] key_raw;
  logic [NKEYS-1:0] key_meta_q;
  logic [NKEYS-1:0] key_sync_q;
  logic [NKEYS-1:0] key_state_q, key_state_d;
  logic [NKEYS-1:0] key_prev_q;
  logic [DB_W-1:0]  db_cnt_q [NKEYS];
  logic [DB_W-1:0]  db_cnt_d [NKEYS];
  logic [NKEYS-1:0] press_c;
  logic             multi_c;

  state_e           state_q, state_d;
  logic [2:0]       step_q, step_d;
  logic [TO_W-1:0]  tmo_q, tmo_d;
  logic             fwd_q, fwd_d;
  logic             rev_q, rev_d;
  logic             err_q, err_d;
  logic [NKEYS-1:0] exp_key;
  logic             accept;
  logic             abort;

  assign key_raw = {kc.key4, kc.key3, kc.key2, kc.key1};

  // Two-flop synchronizer, idles at released (1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta_q <= '1;
      key_sync_q <= '1;
    end else begin
      key_meta_q <= key_raw;
      key_sync_q <= key_meta_q;
    end
  end

  // Debounce: count while the pressed level disagrees with key_state;
  // the count never passes DB_MAX because hitting it clears it.
  always_comb begin
    key_state_d = key_state_q;
    for (int i = 0; i < NKEYS; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (~key_sync_q[i] == key_state_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_W'(DB_MAX)) begin
        key_state_d[i] = ~key_sync_q[i];
        db_cnt_d[i]    = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_state_q <= '0;
      key_prev_q  <= '0;
      for (int i = 0; i < NKEYS; i++) db_cnt_q[i] <= '0;
    end else begin
      key_state_q <= key_state_d;
      key_prev_q  <= key_state_q;
      for (int i = 0; i < NKEYS; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // Press events: rising edges of the debounced level only
  assign press_c = key_state_q & ~key_prev_q;
  assign multi_c = (press_c & (press_c - NKEYS'(1))) != '0;

  // Sequence FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      tmo_q   <= '0;
      fwd_q   <= 1'b0;
      rev_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      tmo_q   <= tmo_d;
      fwd_q   <= fwd_d;
      rev_q   <= rev_d;
      err_q   <= err_d;
    end
  end

  // Sequence FSM next state; a press in the timeout cycle takes priority
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    tmo_d   = tmo_q;
    fwd_d   = 1'b0;
    rev_d   = 1'b0;
    err_d   = 1'b0;
    accept  = 1'b0;
    abort   = 1'b0;

    case (state_q)
      FWD:     exp_key = NKEYS'(4'b0001 << step_q);
      REV:     exp_key = NKEYS'(4'b1000 >> step_q);
      default: exp_key = '0;
    endcase

    if (press_c != '0) begin
      if (multi_c) begin
        abort = 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (press_c == 4'b0001) begin
              state_d = FWD;
              step_d  = 3'd1;
              accept  = 1'b1;
            end else if (press_c == 4'b1000) begin
              state_d = REV;
              step_d  = 3'd1;
              accept  = 1'b1;
            end else begin
              abort = 1'b1;
            end
          end
          default: begin
            if (press_c == exp_key) begin
              accept = 1'b1;
              if (step_q == 3'd3) begin
                fwd_d   = (state_q == FWD);
                rev_d   = (state_q == REV);
                step_d  = 3'd0;
                state_d = IDLE;
              end else begin
                step_d = step_q + 3'd1;
              end
            end else begin
              abort = 1'b1;
            end
          end
        endcase
      end
    end else if ((state_q != IDLE) && (tmo_q == TO_W'(TO_MAX))) begin
      abort = 1'b1;
    end

    if (abort) begin
      err_d   = 1'b1;
      step_d  = 3'd0;
      state_d = IDLE;
    end

    // Inter-press timer: idle at 0, restarted by each accepted press, saturating
    if ((state_d == IDLE) || accept) begin
      tmo_d = '0;
    end else if (tmo_q != TO_W'(TO_MAX)) begin
      tmo_d = tmo_q + TO_W'(1);
    end
  end

  assign kc.key_state = key_state_q;
  assign kc.step      = step_q;
  assign kc.fwd_ok    = fwd_q;
  assign kc.rev_ok    = rev_q;
  assign kc.seq_err   = err_q;

endmodule

// File: doc/key_chain_detector.md
KEY_CHAIN_DETECTOR -- requirements
Module: key_chain_detector

Interface
REQ-001 Parameter: CPU_CLK, default 25_000_000; clk frequency in Hz, informational only, used to derive the other defaults.
REQ-002 Parameter: DEBOUNCE_CYCLES, default 250_000; stable cycles (10 ms) required before a key change is accepted.
REQ-003 Parameter: STEP_TIMEOUT, default 25_000_000; maximum cycles (1 s) allowed between accepted presses within a sequence.
REQ-004 Port clk, input, 1: single system clock; all logic SHALL be on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 Ports key1, key2, key3, key4, input, 1 each: raw push-buttons, active-low (0 = pressed), asynchronous to clk.
REQ-007 Port key_state, output, 4: debounced key levels, active-high (bit0 = key1 ... bit3 = key4).
REQ-008 Port step, output, 3: number of keys correctly pressed in the current sequence (0-3).
REQ-009 Port fwd_ok, output, 1: one-cycle pulse on completion of the order key1, key2, key3, key4.
REQ-010 Port rev_ok, output, 1: one-cycle pulse on completion of the order key4, key3, key2, key1.
REQ-011 Port seq_err, output, 1: one-cycle pulse when a sequence is aborted.

Function
REQ-012 Each key SHALL pass through a 2-flop synchronizer, with both flops reset to 1 (released).
REQ-013 Debounce, per key: the counter SHALL increment while the synchronized level differs from key_state and SHALL clear on any cycle it matches.
REQ-014 On the counter reaching DEBOUNCE_CYCLES-1, key_state SHALL take the new level on the next edge and the counter SHALL clear.
REQ-015 A press event SHALL be a one-cycle internal pulse on a 0->1 transition of key_state; releases SHALL be ignored by the FSM.
REQ-016 FSM states SHALL be IDLE, FWD and REV.
REQ-017 IDLE: a key1 press SHALL go to FWD with step=1; a key4 press SHALL go to REV with step=1; a key2 or key3 press SHALL pulse seq_err and remain in IDLE.
REQ-018 FWD: a press of key(step+1) SHALL increment step; a press of key4 at step=3 SHALL pulse fwd_ok, set step=0 and go to IDLE.
REQ-019 REV: a press of key(4-step) SHALL increment step; a press of key1 at step=3 SHALL pulse rev_ok, set step=0 and go to IDLE.
REQ-020 In FWD or REV, a wrong key SHALL pulse seq_err, set step=0 and go to IDLE; a re-press of an already accepted key counts as a wrong key.
REQ-021 Two or more press events in one cycle SHALL count as a wrong key in every state, including IDLE.
REQ-022 Timeout counter: cleared on every accepted press and held at 0 in IDLE.
REQ-023 The timeout counter SHALL reach STEP_TIMEOUT-1 only after STEP_TIMEOUT cycles without an accepted press; seq_err SHALL then pulse, step=0, and the FSM SHALL go to IDLE.
REQ-024 A valid press in the same cycle as the timeout SHALL be accepted and the timeout discarded.
REQ-025 fwd_ok, rev_ok and seq_err SHALL be registered, mutually exclusive, and asserted exactly one clk after the key_state edge that caused them.
REQ-026 The timeout counter SHALL be wide enough for STEP_TIMEOUT and SHALL saturate, never wrap.
REQ-027 The debounce counters SHALL be wide enough for DEBOUNCE_CYCLES and SHALL saturate, never wrap.

Reset
REQ-028 While rst_n=0, all of the following SHALL be cleared immediately regardless of clk: key_state=4'b0000, step=0, fwd_ok=rev_ok=seq_err=0, FSM=IDLE, all counters 0.
REQ-029 A key held pressed through reset release SHALL produce a press event after DEBOUNCE_CYCLES plus synchronizer latency.
REQ-030 Reset asserted mid-sequence SHALL discard progress with no pulse generated.

Verification (DEBOUNCE_CYCLES=4, STEP_TIMEOUT=100)
REQ-031 Scenario: press key1..key4 in turn, 20 cycles apart -> step 1,2,3; single fwd_ok pulse; step=0; seq_err never asserted.
REQ-032 Scenario: press key4, key3, key2, key1 -> single rev_ok pulse; fwd_ok stays 0.
REQ-033 Scenario: key1 bounces (toggles every 2 cycles for 12 cycles, then held low) -> key_state[0] rises exactly once, 4 cycles after the input settles plus 2-cycle synchronizer delay.
REQ-034 Scenario: key1, then key3 -> seq_err pulse on key3 acceptance; step=0.
REQ-035 Scenario: key1, then no press for 100 cycles -> seq_err pulse at cycle 100; a key2 press at cycle 99 instead -> step=2 and no seq_err.
REQ-036 Scenario: key1, key2, then rst_n low for 3 cycles mid-sequence -> all outputs 0 asynchronously; a subsequent key3 press -> seq_err from IDLE.
